// File: rtl/laser_vin_burst_writer.sv
// Purpose : packs 64-bit laser samples into MEM_DATA_BITS words, buffers them and writes fixed-length DDR bursts.
// Latency : a word enters the FIFO on the edge its last lane is written; a burst request follows one cycle after the threshold is met.
// Backpres: words arriving at a full FIFO are dropped whole (sticky overflow_o); optional drop counter under macro VIN_DROP_CNT_EN.
module laser_vin_burst_writer #(
   parameter real TCQ           = 0.1,
   parameter int  MEM_SEL_BIT   = 1,
   parameter int  MEM_SEL       = 0,
   parameter int  ADDR_WIDTH    = 30,
   parameter int  DATA_WIDTH    = 32,
   parameter int  MEM_DATA_BITS = 256,
   parameter int  BURST_LEN     = 128,
   parameter int  FIFO_DEPTH    = 256
) (
   input  logic                     ddr_clk_i,
   input  logic                     ddr_rst_i,
   input  logic                     laser_start_i,
   input  logic                     laser_data_vld_i,
   input  logic [DATA_WIDTH+31:0]   laser_data_i,
   output logic [17:0]              wr_burst_line_o,
   output logic                     overflow_o,
`ifdef VIN_DROP_CNT_EN
   output logic [15:0]              drop_cnt_o,
`endif
   output logic                     wr_ddr_req_o,
   output logic [7:0]               wr_ddr_len_o,
   output logic [ADDR_WIDTH-1:0]    wr_ddr_addr_o,
   input  logic                     wr_ddr_data_req_i,
   output logic [MEM_DATA_BITS-1:0] wr_ddr_data_o,
   input  logic                     wr_ddr_finish_i
);

   localparam int SW  = DATA_WIDTH + 32;
   localparam int N   = MEM_DATA_BITS / SW;
   localparam int LW  = (N > 1) ? $clog2(N) : 1;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int OW  = ADDR_WIDTH - MEM_SEL_BIT;
   localparam int UPW = MEM_DATA_BITS / DATA_WIDTH;

   // TCQ is a simulation-only delay; it is only range-checked here.
   if ((MEM_DATA_BITS % SW) != 0 || BURST_LEN < 1 || BURST_LEN > 255 ||
       FIFO_DEPTH < 2 * BURST_LEN || (1 << AW) != FIFO_DEPTH || TCQ < 0.0) begin : g_bad_param
      $error("laser_vin_burst_writer: illegal parameter set");
   end

   typedef enum logic [1:0] {IDLE, REQ, DATA, WAIT_FIN} state_t;

   state_t                   state;
   logic                     start_d, clr_pend, flush_pend, fin_held;
   logic [LW-1:0]            lane, lane_b;
   logic [MEM_DATA_BITS-1:0] pack_word, word_b, word_nxt;
   logic [MEM_DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]            wr_ptr, rd_ptr, wr_b, rd_b;
   logic [AW:0]              count, count_b;
   logic [7:0]               pops_left, burst_len;
   logic [OW-1:0]            offset;
   logic start_rise, start_fall, fin_evt, do_clear, accept, push, pop, push_ok, drop, go;

   // Edge detection, deferred-clear resolution, packer lane steering and FIFO handshake terms.
   always_comb begin
      start_rise = laser_start_i & ~start_d;
      start_fall = ~laser_start_i & start_d;
      fin_evt    = (state == WAIT_FIN) && (wr_ddr_finish_i || fin_held);
      // A new capture window wipes state only when no burst is in flight.
      do_clear   = (start_rise || clr_pend) && (state == IDLE || fin_evt);
      accept     = laser_start_i & laser_data_vld_i;
      lane_b     = do_clear ? '0 : lane;
      word_b     = do_clear ? '0 : pack_word;
      wr_b       = do_clear ? '0 : wr_ptr;
      rd_b       = do_clear ? '0 : rd_ptr;
      count_b    = do_clear ? '0 : count;
      word_nxt   = word_b;
      for (int i = 0; i < N; i++) begin
         if (accept && lane_b == LW'(i)) word_nxt[i*SW +: SW] = laser_data_i;
      end
      // Unused lanes are already zero, so a flush pushes the partial word as-is.
      push      = (accept && lane_b == LW'(N-1)) || (start_fall && lane_b != '0);
      pop       = (state == REQ || state == DATA) && wr_ddr_data_req_i && pops_left != 8'd0;
      push_ok   = push && (count_b != (AW+1)'(FIFO_DEPTH) || pop);
      drop      = push && !push_ok;
      go        = (count >= (AW+1)'(BURST_LEN)) || (flush_pend && count != '0);
      burst_len = (count >= (AW+1)'(BURST_LEN)) ? 8'(BURST_LEN) : 8'(count);
      wr_ddr_data_o = (state == REQ || state == DATA) ? mem[rd_ptr] : '0;
   end

   // Packer lanes and start-edge history.
   always_ff @(posedge ddr_clk_i) begin
      if (ddr_rst_i) begin
         start_d   <= 1'b0;
         lane      <= '0;
         pack_word <= '0;
      end else begin
         start_d   <= laser_start_i;
         lane      <= push ? '0 : (accept ? lane_b + LW'(1) : lane_b);
         pack_word <= push ? '0 : word_nxt;
      end
   end

   // Word FIFO storage; pointers below make stale contents unreachable.
   always_ff @(posedge ddr_clk_i) begin
      if (push_ok) mem[wr_b] <= word_nxt;
   end

   // Word FIFO pointers and occupancy.
   always_ff @(posedge ddr_clk_i) begin
      if (ddr_rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_b + AW'(push_ok);
         rd_ptr <= rd_b + AW'(pop);
         count  <= count_b + (AW+1)'(push_ok) - (AW+1)'(pop);
      end
   end

   // Burst FSM with address offset, completed-line count and capture-window bookkeeping.
   always_ff @(posedge ddr_clk_i) begin
      if (ddr_rst_i) begin
         state           <= IDLE;
         wr_ddr_req_o    <= 1'b0;
         wr_ddr_len_o    <= '0;
         wr_ddr_addr_o   <= '0;
         pops_left       <= '0;
         fin_held        <= 1'b0;
         offset          <= '0;
         wr_burst_line_o <= '0;
         overflow_o      <= 1'b0;
         clr_pend        <= 1'b0;
         flush_pend      <= 1'b0;
      end else begin
         overflow_o <= drop | (overflow_o & ~do_clear);
         if (do_clear)        clr_pend <= 1'b0;
         else if (start_rise) clr_pend <= 1'b1;
         if (start_fall)                       flush_pend <= 1'b1;
         else if (do_clear || count == '0)     flush_pend <= 1'b0;
         if (pop) pops_left <= pops_left - 8'd1;
         if ((state == REQ || state == DATA) && wr_ddr_finish_i) fin_held <= 1'b1;
         case (state)
            IDLE: begin
               if (!do_clear && go) begin
                  state         <= REQ;
                  wr_ddr_req_o  <= 1'b1;
                  wr_ddr_len_o  <= burst_len;
                  pops_left     <= burst_len;
                  wr_ddr_addr_o <= {MEM_SEL_BIT'(MEM_SEL), offset};
                  fin_held      <= 1'b0;
               end
            end
            REQ: begin
               if (wr_ddr_data_req_i) begin
                  wr_ddr_req_o <= 1'b0;
                  state        <= (pops_left == 8'd1) ? WAIT_FIN : DATA;
               end
            end
            DATA: begin
               if (pop && pops_left == 8'd1) state <= WAIT_FIN;
            end
            WAIT_FIN: begin
               if (fin_evt) begin
                  state    <= IDLE;
                  fin_held <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
         if (do_clear) begin
            offset          <= '0;
            wr_burst_line_o <= '0;
         end else if (fin_evt) begin
            offset          <= offset + OW'(32'(wr_ddr_len_o) * UPW);
            wr_burst_line_o <= wr_burst_line_o + 18'd1;
         end
      end
   end

`ifdef VIN_DROP_CNT_EN
   // Saturating count of discarded packed words within the current capture window.
   always_ff @(posedge ddr_clk_i) begin
      if (ddr_rst_i) begin
         drop_cnt_o <= '0;
      end else if (do_clear) begin
         drop_cnt_o <= drop ? 16'd1 : 16'd0;
      end else if (drop && drop_cnt_o != 16'hFFFF) begin
         drop_cnt_o <= drop_cnt_o + 16'd1;
      end
   end
`endif

endmodule
